// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider helper and
// the 8N1 frame shape used by the RX (and later TX) path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per bit; truncating division.
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter. A push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [width-1:0]         push_data,
    input  logic                     pop,
    output logic [width-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int AW = $clog2(depth);

    generate
        if (depth < 2 || (1 << AW) != depth) begin : g_depth_check
            $error("uart_sync_fifo: depth must be a power of two and at least 2");
        end
    endgenerate

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage array; not reset since the output is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive front end: synchronises rxd, deframes 8N1 characters with a
// mid-bit sampling FSM and queues them in a FIFO presented as valid/ready.
// Overrun and framing errors are sticky until clr_err; a set beats a clear.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int clk_freq   = 162000000,
    parameter int uart_baud  = 9600,
    parameter int fifo_depth = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(fifo_depth):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int DIV  = uart_div(clk_freq, uart_baud);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx_buffer: clk_freq / uart_baud must be at least 4");
        end
    endgenerate

    rx_state_t      state;
    rx_state_t      next_state;
    logic           rx_sync1;
    logic           rxs;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bit_idx;
    logic [7:0]     shift_reg;
    logic           cnt_clear;
    logic           bit_clear;
    logic           shift_en;
    logic           push_byte;
    logic           frame_set;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1 <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rx_sync1 <= rxd;
            rxs      <= rx_sync1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and sampling strobes; each state samples at its own count.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        bit_clear  = 1'b0;
        shift_en   = 1'b0;
        push_byte  = 1'b0;
        frame_set  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (!rxs) begin
                    next_state = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clear = 1'b1;
                    if (!rxs) begin
                        bit_clear  = 1'b1;
                        next_state = DATA;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_clear = 1'b1;
                    if (rxs) begin
                        push_byte  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        next_state = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_clear = 1'b1;
                if (rxs) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bit-time counter, data bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (cnt_clear) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (bit_clear) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {rxs, shift_reg[7:1]};
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_byte && fifo_full && !pop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    uart_sync_fifo #(
        .width (DATA_BITS),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_byte),
        .push_data (shift_reg),
        .pop       (rx_ready),
        .rd_data   (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

endmodule
